// File: rtl/execute_sequencer.sv
// execute_sequencer
//   Multi-cycle control FSM for the RV32I minimum core. Owns the program
//   counter, fetches instructions over a valid/ready handshake, steps each
//   instruction through decode, execute, optional memory access and
//   writeback, gates the register-file write, commits redirects, counts
//   retired instructions and halts on illegal instructions or misaligned
//   redirect targets.
//
// Ports
//   clock, reset_n                 clock and asynchronous active-low reset
//   run                            start permission (sampled in IDLE/WRITEBACK)
//   imem_valid/addr/ready/rdata    instruction fetch handshake
//   instruction                    latched instruction word
//   alu_*_enable                   decode class flags
//   execute_enable                 execute-unit strobe
//   next_pc_valid, next_pc         redirect from the execute unit
//   dmem_valid/write/ready         data access handshake
//   register_file_write_enable     writeback strobe
//   pc, instret, halted, state     architectural / debug state
module execute_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    input  logic        alu_branch_enable,
    input  logic        alu_unconditional_jal_enable,
    input  logic        alu_unconditional_jalr_enable,
    input  logic        alu_upper_immediate_lui_enable,
    input  logic        alu_upper_immediate_auipc_enable,
    input  logic        alu_register_immediate_enable,
    input  logic        alu_register_register_enable,
    input  logic        alu_load_enable,
    input  logic        alu_store_enable,
    output logic        execute_enable,
    input  logic        next_pc_valid,
    input  logic [31:0] next_pc,
    output logic        dmem_valid,
    output logic        dmem_write,
    input  logic        dmem_ready,
    output logic        register_file_write_enable,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        halted,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instruction_q, instruction_d;
    logic [31:0] instret_q, instret_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_target_q, redir_target_d;
    logic        is_store_q, is_store_d;
    logic        no_write_q, no_write_d;

    logic any_class;
    logic wb_fault;
    logic rd_is_zero;

    assign any_class = alu_branch_enable | alu_unconditional_jal_enable |
                       alu_unconditional_jalr_enable | alu_upper_immediate_lui_enable |
                       alu_upper_immediate_auipc_enable | alu_register_immediate_enable |
                       alu_register_register_enable | alu_load_enable | alu_store_enable;

    // A captured redirect to a non-word-aligned target faults in WRITEBACK.
    assign wb_fault   = redir_valid_q && (redir_target_q[1:0] != 2'b00);
    assign rd_is_zero = (instruction_q[11:7] == 5'd0);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instruction_d  = instruction_q;
        instret_d      = instret_q;
        redir_valid_d  = redir_valid_q;
        redir_target_d = redir_target_q;
        is_store_d     = is_store_q;
        no_write_d     = no_write_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    instruction_d = imem_rdata;
                    state_d       = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = any_class ? S_EXECUTE : S_HALT;
            end
            S_EXECUTE: begin
                // Class flags are captured here so the memory and writeback
                // outputs depend only on registered state.
                redir_valid_d  = next_pc_valid;
                redir_target_d = next_pc;
                is_store_d     = alu_store_enable;
                no_write_d     = alu_branch_enable | alu_store_enable;
                state_d        = (alu_load_enable | alu_store_enable) ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                if (dmem_ready) state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                if (wb_fault) begin
                    state_d = S_HALT;
                end else begin
                    pc_d      = redir_valid_q ? redir_target_q : pc_q + 32'd4;
                    instret_d = instret_q + 32'd1;
                    state_d   = run ? S_FETCH : S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // Unused encoding recovers to IDLE.
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            pc_q           <= RESET_PC;
            instruction_q  <= 32'd0;
            instret_q      <= 32'd0;
            redir_valid_q  <= 1'b0;
            redir_target_q <= 32'd0;
            is_store_q     <= 1'b0;
            no_write_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instruction_q  <= instruction_d;
            instret_q      <= instret_d;
            redir_valid_q  <= redir_valid_d;
            redir_target_q <= redir_target_d;
            is_store_q     <= is_store_d;
            no_write_q     <= no_write_d;
        end
    end

    assign imem_valid     = (state_q == S_FETCH);
    assign imem_addr      = pc_q;
    assign execute_enable = (state_q == S_EXECUTE);
    assign dmem_valid     = (state_q == S_MEMORY);
    assign dmem_write     = (state_q == S_MEMORY) && is_store_q;
    assign register_file_write_enable = (state_q == S_WRITEBACK) && !wb_fault &&
                                        !no_write_q && !rd_is_zero;
    assign halted         = (state_q == S_HALT);
    assign instruction    = instruction_q;
    assign pc             = pc_q;
    assign instret        = instret_q;
    assign state          = state_q;

endmodule
